// File: rtl/vec_to_pixel.sv
// Float RGB vector to RGB888 pixel converter with raster framing.
// Stage 1 decodes each float, stage 2 shifts/saturates and holds the output beat.
module vec_to_pixel #(
    parameter int SIZE  = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [2:0][SIZE-1:0] s_axis_a_tdata,
    input  logic                 s_axis_a_tvalid,
    output logic                 s_axis_a_tready,
    output logic [23:0]          m_axis_pixel_tdata,
    output logic                 m_axis_pixel_tvalid,
    input  logic                 m_axis_pixel_tready,
    output logic                 m_axis_pixel_tuser,
    output logic                 m_axis_pixel_tlast
);

    localparam int HW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int VW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [EXP_W:0]   BIAS     = (EXP_W+1)'((1 << (EXP_W-1)) - 1);
    localparam logic [EXP_W:0]   SAT_E    = BIAS + (EXP_W+1)'(8);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [HW-1:0]    H_LAST   = HW'(H_RES - 1);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_RES - 1);

    // Handshake: a beat moves on the rising edge where both valid and ready are high.
    // A stage loads when it is empty or the stage after it is unloading.
    logic v1, v2, ready2;

    assign ready2              = !v2 || m_axis_pixel_tready;
    assign s_axis_a_tready     = !v1 || ready2;
    assign m_axis_pixel_tvalid = v2;

    logic [2:0]      c_zero, c_sat, s1_zero, s1_sat;
    logic [2:0][2:0] c_shift, s1_shift;
    logic [2:0][7:0] c_sig, s1_sig;
    logic            sgn;
    logic [EXP_W-1:0] ex;
    logic [MAN_W-1:0] man;
    logic [EXP_W:0]   ex_x;

    // Only the top 8 significand bits can reach the result since e <= 7.
    always_comb begin
        c_zero  = '0;
        c_sat   = '0;
        c_shift = '0;
        c_sig   = '0;
        sgn     = 1'b0;
        ex      = '0;
        man     = '0;
        ex_x    = '0;
        for (int i = 0; i < 3; i++) begin
            sgn  = s_axis_a_tdata[i][SIZE-1];
            ex   = s_axis_a_tdata[i][SIZE-2 -: EXP_W];
            man  = s_axis_a_tdata[i][MAN_W-1:0];
            ex_x = {1'b0, ex};
            c_zero[i]  = sgn || ((ex == EXP_ONES) && (man != '0)) || (ex_x < BIAS);
            c_sat[i]   = !c_zero[i] && ((ex == EXP_ONES) || (ex_x >= SAT_E));
            c_shift[i] = ex[2:0] - BIAS[2:0];
            c_sig[i]   = {1'b1, man[MAN_W-1 -: 7]};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1       <= 1'b0;
            s1_zero  <= '0;
            s1_sat   <= '0;
            s1_shift <= '0;
            s1_sig   <= '0;
        end else if (s_axis_a_tready) begin
            v1 <= s_axis_a_tvalid;
            if (s_axis_a_tvalid) begin
                s1_zero  <= c_zero;
                s1_sat   <= c_sat;
                s1_shift <= c_shift;
                s1_sig   <= c_sig;
            end
        end
    end

    logic [23:0] pix_next;

    always_comb begin
        pix_next = '0;
        for (int i = 0; i < 3; i++) begin
            if (s1_zero[i])
                pix_next[23-8*i -: 8] = 8'h00;
            else if (s1_sat[i])
                pix_next[23-8*i -: 8] = 8'hFF;
            else
                pix_next[23-8*i -: 8] = s1_sig[i] >> (3'd7 - s1_shift[i]);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v2                 <= 1'b0;
            m_axis_pixel_tdata <= '0;
        end else if (ready2) begin
            v2 <= v1;
            if (v1)
                m_axis_pixel_tdata <= pix_next;
        end
    end

    // Raster position follows emitted beats only, never accepted ones.
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hcount <= '0;
            vcount <= '0;
        end else if (v2 && m_axis_pixel_tready) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    assign m_axis_pixel_tuser = (hcount == '0) && (vcount == '0);
    assign m_axis_pixel_tlast = (hcount == H_LAST);

endmodule

// File: tb/tb_vec_to_pixel.sv
// Scoreboard bench for vec_to_pixel: conversion corners, packing, streaming,
// framing, random backpressure and mid-frame reset.
module tb_vec_to_pixel;

    localparam int H = 4;
    localparam int V = 2;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [2:0][31:0] s_tdata;
    logic            s_tvalid, s_tready;
    logic [23:0]     m_tdata;
    logic            m_tvalid, m_tready, m_tuser, m_tlast;

    always #5 aclk = ~aclk;

    vec_to_pixel #(.SIZE(32), .EXP_W(8), .MAN_W(23), .H_RES(H), .V_RES(V)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .s_axis_a_tdata      (s_tdata),
        .s_axis_a_tvalid     (s_tvalid),
        .s_axis_a_tready     (s_tready),
        .m_axis_pixel_tdata  (m_tdata),
        .m_axis_pixel_tvalid (m_tvalid),
        .m_axis_pixel_tready (m_tready),
        .m_axis_pixel_tuser  (m_tuser),
        .m_axis_pixel_tlast  (m_tlast)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int out_idx = 0;
    int occ = 0;
    int rdy_pct = 100;
    bit lat_chk = 1'b0;
    bit prev_stall = 1'b0;
    logic [25:0] held = '0;
    logic [23:0] exp_q[$];
    int acc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] conv(input logic [31:0] f);
        int e;
        logic [23:0] sig;
        if (f[31]) return 8'h00;
        if (f[30:23] == 8'hFF) return (f[22:0] != 0) ? 8'h00 : 8'hFF;
        e = int'(f[30:23]) - 127;
        if (e < 0) return 8'h00;
        if (e >= 8) return 8'hFF;
        sig = {1'b1, f[22:0]};
        return 8'(sig >> (23 - e));
    endfunction

    function automatic logic [31:0] rand_f();
        logic [31:0] f;
        f = $urandom;
        f[30:23] = 8'($urandom_range(118, 138));
        f[31] = ($urandom_range(0, 9) == 0);
        return f;
    endfunction

    always @(posedge aclk) cyc++;

    always @(posedge aclk) begin
        #1;
        m_tready = ($urandom_range(0, 99) < rdy_pct);
    end

    // Output monitor: pops the scoreboard and tracks pipeline occupancy.
    always @(negedge aclk) begin
        logic [23:0] e;
        int a;
        if (aresetn === 1'b1) begin
            if (prev_stall) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_beat", 32'({m_tuser, m_tlast, m_tdata}), 32'(held));
            end
            if (!s_tready) check("ready_low_occ", 32'(occ), 32'd2);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(m_tdata), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("data", 32'(m_tdata), 32'(e));
                    if (lat_chk) check("latency", 32'(cyc - a), 32'd2);
                end
                check("tuser", 32'(m_tuser), 32'((out_idx % (H * V)) == 0));
                check("tlast", 32'(m_tlast), 32'((out_idx % H) == H - 1));
                out_idx++;
            end
            occ += int'(s_tvalid && s_tready) - int'(m_tvalid && m_tready);
            prev_stall = m_tvalid && !m_tready;
            held = {m_tuser, m_tlast, m_tdata};
        end
    end

    task automatic drive_beat(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                              input logic [23:0] exp, output int waits);
        bit ok;
        int hc;
        s_tdata  = {b, g, r};
        s_tvalid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge aclk);
            ok = s_tready;
            hc = cyc;
            @(posedge aclk);
            #1;
            if (ok) break;
            waits++;
            if (waits > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        s_tvalid = 1'b0;
        if (ok) begin
            exp_q.push_back(exp);
            acc_q.push_back(hc);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(posedge aclk);
            #3;
            n++;
            if (n > budget) begin
                check("drain_timeout", 32'(exp_q.size()), 32'd0);
                break;
            end
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_tuser", 32'(m_tuser), 32'd1);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        exp_q.delete();
        acc_q.delete();
        occ = 0;
        out_idx = 0;
        prev_stall = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        check("rst_s_ready", 32'(s_tready), 32'd1);
    endtask

    logic [31:0] corner_f[9] = '{32'h437F0000, 32'h42C80000, 32'h3FC00000,
                                 32'h3F7FFFFF, 32'h80000000, 32'hC2C80000,
                                 32'h43800000, 32'h7F800000, 32'h7FC00000};
    logic [7:0]  corner_e[9] = '{8'hFF, 8'h64, 8'h01, 8'h00, 8'h00, 8'h00,
                                 8'hFF, 8'hFF, 8'h00};

    initial begin
        int w;
        int n;
        logic [31:0] r, g, b;
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #2;
        do_reset();

        // Corners and packing: ten back-to-back beats also form the framing test.
        lat_chk = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_beat(corner_f[i], 32'h0, 32'h0, {corner_e[i], 16'h0000}, w);
            check("corner_no_stall", 32'(w), 32'd0);
        end
        drive_beat(32'h42C80000, 32'h3FC00000, 32'h437F0000, 24'h6401FF, w);
        check("pack_no_stall", 32'(w), 32'd0);
        wait_drain(50);

        for (int i = 0; i < 16; i++) begin
            r = rand_f();
            g = rand_f();
            b = rand_f();
            drive_beat(r, g, b, {conv(r), conv(g), conv(b)}, w);
            check("stream_no_stall", 32'(w), 32'd0);
        end
        wait_drain(50);

        lat_chk = 1'b0;
        rdy_pct = 70;
        for (int i = 0; i < 40; i++) begin
            r = rand_f();
            g = rand_f();
            b = rand_f();
            drive_beat(r, g, b, {conv(r), conv(g), conv(b)}, w);
        end
        wait_drain(500);
        rdy_pct = 100;

        // Mid-frame reset with two beats stuck in the pipeline.
        @(posedge aclk);
        #2;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            r = rand_f();
            drive_beat(r, 32'h0, 32'h0, {conv(r), 16'h0000}, w);
        end
        n = 0;
        while (out_idx < 5 && n < 50) begin
            @(posedge aclk);
            #3;
            n++;
        end
        check("five_outputs", 32'(out_idx), 32'd5);
        rdy_pct = 0;
        for (int i = 0; i < 2; i++) begin
            r = rand_f();
            drive_beat(r, 32'h0, 32'h0, {conv(r), 16'h0000}, w);
        end
        repeat (2) @(posedge aclk);
        #3;
        check("pre_reset_valid", 32'(m_tvalid), 32'd1);
        rdy_pct = 100;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            r = rand_f();
            g = rand_f();
            drive_beat(r, g, 32'h0, {conv(r), conv(g), 8'h00}, w);
        end
        wait_drain(50);
        check("final_out_count", 32'(out_idx), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
